// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   DATA_BITS        - payload width of one serial frame (8N1).
//   uart_rx_state_t  - receiver line state machine encoding.
//   shift_in_lsb     - shift one serial bit into a frame register, LSB first.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  // Bits arrive LSB first, so each new bit enters at the MSB end and
  // the earliest bit ends up in bit 0 after DATA_BITS shifts.
  function automatic logic [DATA_BITS-1:0] shift_in_lsb(
    input logic [DATA_BITS-1:0] sr,
    input logic                 b
  );
    return {b, sr[DATA_BITS-1:1]};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk - destination clock
//   rst - synchronous active-high reset; both flops load RST_VAL
//   d   - asynchronous input
//   q   - synchronized output (second flop)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture; only the second stage is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 serial receiver with a one-entry output holding register.
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial line, idle high, LSB first
//   data      - received byte, stable while valid is high
//   valid     - data holds an unconsumed byte
//   ready     - consumer takes data when valid && ready at a rising edge
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   overrun   - one-cycle pulse when a completed byte is dropped because
//               the previous one was still unconsumed
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_ZERO      = 3'd0;
  localparam logic [2:0]       IDX_ONE       = 3'd1;
  localparam logic [2:0]       IDX_LAST      = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_t       state_r;
  uart_rx_state_t       state_next_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_next_s;
  logic [2:0]           idx_r;
  logic [2:0]           idx_next_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_next_s;
  logic                 deliver_s;
  logic                 ferr_s;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // Line state machine registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      idx_r   <= idx_next_s;
      shift_r <= shift_next_s;
    end
  end

  // Next-state logic: the bit-cycle counter runs freely inside a state and
  // is cleared whenever a sample is taken, so every sample lands one full
  // bit period after the previous one, starting from mid start bit.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r + CNT_ONE;
    idx_next_s   = idx_r;
    shift_next_s = shift_r;
    deliver_s    = 1'b0;
    ferr_s       = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_next_s = CNT_ZERO;
        idx_next_s = IDX_ZERO;
        if (!rx_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_HALF_LAST) begin
          cnt_next_s = CNT_ZERO;
          idx_next_s = IDX_ZERO;
          // A start bit that is already high again at mid-bit is a glitch.
          if (!rx_s) begin
            state_next_s = DATA;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_next_s   = CNT_ZERO;
          shift_next_s = shift_in_lsb(shift_r, rx_s);
          if (idx_r == IDX_LAST) begin
            idx_next_s   = IDX_ZERO;
            state_next_s = STOP;
          end else begin
            idx_next_s   = idx_r + IDX_ONE;
            state_next_s = DATA;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_next_s = CNT_ZERO;
          if (rx_s) begin
            deliver_s    = 1'b1;
            state_next_s = IDLE;
          end else begin
            ferr_s       = 1'b1;
            state_next_s = WAIT_HIGH;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        cnt_next_s = CNT_ZERO;
        if (rx_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_HIGH;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
        idx_next_s   = IDX_ZERO;
      end
    endcase
  end

  // Output holding register and status pulses. A delivery in the same
  // cycle as a consumption replaces the byte, so no overrun is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r      <= {DATA_BITS{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= ferr_s;
      overrun_r   <= 1'b0;
      if (deliver_s) begin
        if (!valid_r || ready) begin
          data_r  <= shift_r;
          valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: self-checking bench for uart_rx at CLOCKS_PER_BIT = 8.
// Expected bytes are pushed to a scoreboard queue when a frame is driven
// and popped by a monitor whenever the DUT hands a byte over.
module tb_uart_rx;

  localparam int C        = 8;
  localparam int LATENCY  = 2 + C / 2 + 9 * C;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int         cyc;
  int         start_cyc;
  int         last_lat;
  int         n_cmp;
  int         n_bad;
  int         n_vhi;
  int         n_fe;
  int         n_ov;
  int         s_vhi;
  int         s_fe;
  int         s_ov;
  logic       valid_q;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] byte_v;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
    logic       chk_lat;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] hello[13];

  uart_rx #(
    .CLOCKS_PER_BIT(C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (valid && !valid_q) last_lat = cyc - start_cyc;
      if (valid) n_vhi++;
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got 0x%0h expected no byte", data);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", {24'h0, data}, {24'h0, e});
        end
      end
      valid_q = valid;
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * C) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    start_cyc = cyc + 1;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  task automatic snap();
    s_vhi = n_vhi;
    s_fe  = n_fe;
    s_ov  = n_ov;
  endtask

  task automatic expect_counts(input string tag, input int d_vhi, input int d_fe, input int d_ov);
    check({tag, "_valid_cycles"}, n_vhi - s_vhi, d_vhi);
    check({tag, "_frame_err"}, n_fe - s_fe, d_fe);
    check({tag, "_overrun"}, n_ov - s_ov, d_ov);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
    snap();
  endtask

  initial begin
    logic [7:0] b;
    cyc = 0; start_cyc = 0; last_lat = -1;
    n_cmp = 0; n_bad = 0; n_vhi = 0; n_fe = 0; n_ov = 0;
    valid_q = 1'b0;
    rst = 1'b1; rx = 1'b1; ready = 1'b1;

    vecs[0] = '{8'h48, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

    fork
      monitor();
    join_none

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    idle_bits(2);
    snap();

    // Table-driven frames with ready held high
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].byte_v);
      last_lat = -1;
      send_byte(vecs[i].byte_v, vecs[i].stop);
      idle_bits(2);
      expect_counts($sformatf("vec%0d", i), vecs[i].exp_valid ? 1 : 0,
                    vecs[i].exp_ferr ? 1 : 0, 0);
      if (vecs[i].chk_lat) check("latency_0x48", last_lat, LATENCY);
    end

    // Back-to-back "Hello, World!"
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(hello[i]);
      send_byte(hello[i], 1'b1);
    end
    idle_bits(2);
    expect_counts("hello", 13, 0, 0);

    // Short low glitch, then a good frame
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle_bits(3);
    expect_counts("glitch", 0, 0, 0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    idle_bits(2);
    expect_counts("after_glitch", 1, 0, 0);

    // Framing error followed by a long break
    send_byte(8'h55, 1'b0);
    rx = 1'b0;
    repeat (20 * C) @(posedge clk);
    #1;
    idle_bits(2);
    expect_counts("break", 0, 1, 0);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle_bits(2);
    expect_counts("after_break", 1, 0, 0);

    // Overrun with the consumer stalled
    ready = 1'b0;
    send_byte(8'h11, 1'b1);
    idle_bits(2);
    send_byte(8'h22, 1'b1);
    idle_bits(2);
    check("ovr_valid", {31'h0, valid}, 32'h1);
    check("ovr_data", {24'h0, data}, 32'h11);
    check("ovr_pulses", n_ov - s_ov, 1);
    check("ovr_frame_err", n_fe - s_fe, 0);
    exp_q.push_back(8'h11);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("ovr_consumed_valid", {31'h0, valid}, 32'h0);
    check("ovr_consumed_data", {24'h0, data}, 32'h11);
    check("ovr_sb_drained", exp_q.size(), 0);
    ready = 1'b1;
    snap();

    // Reset in the middle of data bit 4 of 0x3C
    b = 8'h3C;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(b[i]);
    rx = b[4];
    repeat (C / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_data", {24'h0, data}, 32'h0);
    check("midrst_valid", {31'h0, valid}, 32'h0);
    check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
    check("midrst_overrun", {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    idle_bits(12);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    idle_bits(2);
    expect_counts("after_rst", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 5, clock cycles per serial bit; legal values >= 4.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 SHALL have port data  output  8  received byte, held stable while valid=1.
REQ-006 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-007 SHALL have port ready  input  1  consumer accepts data when valid&&ready at a rising edge.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because valid=1 and ready=0.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer; the second flop output (rx_s) is the only rx value used internally.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-012 IDLE: rx_s=0 -> START, bit-cycle counter cleared.
REQ-013 START: after CLOCKS_PER_BIT/2 (integer division) cycles, sample rx_s; 0 -> DATA, counter cleared; 1 -> IDLE (glitch), no output, no error.
REQ-014 DATA: sample rx_s every CLOCKS_PER_BIT cycles; shift LSB first into an 8-bit shift register; after the 8th sample -> STOP.
REQ-015 STOP: after CLOCKS_PER_BIT cycles sample rx_s; 1 -> deliver byte, IDLE; 0 -> frame_err=1 for one cycle, byte discarded, WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_s=1, then IDLE (no restart on a held-low break).
REQ-017 Delivery SHALL occur on the edge after the stop sample; valid rises exactly 2 + CLOCKS_PER_BIT/2 + 9*CLOCKS_PER_BIT cycles after the edge at which the first synchronizer flop captures the start-bit 0.
REQ-018 Delivery with valid=0, or valid=1 and ready=1 in the same cycle: data loads new byte, valid=1.
REQ-019 Delivery with valid=1 and ready=0: new byte dropped, data/valid unchanged, overrun=1 for one cycle.
REQ-020 valid&&ready without delivery SHALL clear valid on the next edge; data retains its last value.
REQ-021 Reception SHALL continue independent of ready; ready never stalls the line state machine.
REQ-022 frame_err and overrun SHALL never be asserted in the same cycle as each other for the same frame; frame_err frames never touch data/valid.

Reset
REQ-023 rst=1 SHALL force state=IDLE, counters=0, shift register=0, synchronizer flops=1, data=0x00, valid=0, frame_err=0, overrun=0 on the next edge.
REQ-024 rst mid-frame SHALL abandon the frame silently; after release, the partial frame's remaining low bits may be taken as a start bit and are handled by REQ-013/REQ-015/REQ-016 rules only.

Structure
REQ-025 uart_pkg SHALL hold DATA_BITS=8 and the rx state enum type uart_rx_state_t; uart_tx and uart_rx share the package.
REQ-026 The two-flop synchronizer SHALL be a separate sub-module sync_2ff (reset value parameterised, here 1).
REQ-027 Bit counter width SHALL be $clog2(CLOCKS_PER_BIT); data-bit index 3 bits.

Verification (CLOCKS_PER_BIT=8 unless stated)
REQ-028 Frame 0x48, ready=1 -> data=0x48, valid high exactly 1 cycle, 78 cycles after sync capture of start bit; no error pulses.
REQ-029 uart_tx (same CLOCKS_PER_BIT) looped to rx sending "Hello, World!" back-to-back, ready=1 -> 13 bytes 0x48 0x65 0x6C 0x6C 0x6F 0x2C 0x20 0x57 0x6F 0x72 0x6C 0x64 0x21 in order, no errors.
REQ-030 rx low for 3 cycles then high -> return to IDLE, no valid, no frame_err; following frame 0x5A received correctly.
REQ-031 Frame 0x55 with stop bit 0, rx then held low 20 bit times -> single frame_err pulse, no valid, no further pulses while low; next frame 0xA5 received after rx returns high.
REQ-032 ready=0, frames 0x11 then 0x22 -> data=0x11 valid=1, one overrun pulse at second delivery; ready=1 one cycle -> valid=0, data stays 0x11.
REQ-033 rst pulsed during data bit 4 of 0x3C -> all outputs at reset values next edge; line idled 12 bit times, then frame 0xC3 -> data=0xC3, no errors.
